// File: rtl/inv_subs_layer_seq.sv
// inv_subs_layer_seq: sequential inverse substitution layer.
// A SIZE-bit block is rotated through a working register NPC nibbles at a
// time. Each beat inverse-substitutes the top NPC nibbles and re-enters them
// at the bottom. After K beats every nibble is back at its original position.
module inv_subs_layer_seq #(
    parameter int SIZE = 64,
    parameter int NPC  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_data,
    output logic            busy
);

    localparam int BW = 4 * NPC;                       // bits handled per beat
    localparam int K  = SIZE / BW;                     // beats per block
    localparam int CW = (K > 1) ? $clog2(K) : 1;       // beat counter width
    localparam logic [CW-1:0] LAST_BEAT = CW'(K - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] w_q, w_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   sub_nib;
    logic [SIZE-1:0] w_rot;

    // 4-bit inverse S-box (inverse of C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2).
    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] r;
        r = 4'h0;
        case (x)
            4'h0: r = 4'h5;
            4'h1: r = 4'hE;
            4'h2: r = 4'hF;
            4'h3: r = 4'h8;
            4'h4: r = 4'hC;
            4'h5: r = 4'h1;
            4'h6: r = 4'h2;
            4'h7: r = 4'hD;
            4'h8: r = 4'hB;
            4'h9: r = 4'h4;
            4'hA: r = 4'h6;
            4'hB: r = 4'h3;
            4'hC: r = 4'h0;
            4'hD: r = 4'h7;
            4'hE: r = 4'h9;
            4'hF: r = 4'hA;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    // Substitute the top NPC nibbles of W, keeping their relative order.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sub_nib = '0;
        for (int i = 0; i < NPC; i++) begin
            sub_nib[4*i +: 4] = inv_sbox(w_q[SIZE-BW+4*i +: 4]);
        end
    end

    // Rotate W left by one beat with the substituted nibbles entering at the bottom.
    generate
        if (BW == SIZE) begin : g_single_beat
            assign w_rot = sub_nib;
        end else begin : g_multi_beat
            assign w_rot = {w_q[SIZE-BW-1:0], sub_nib};
        end
    endgenerate

    // Next-state, working register and beat counter.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    w_d     = in_data;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                w_d   = w_rot;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BEAT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset taking priority over all inputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge value regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = w_q;

endmodule

// File: tb/tb_inv_subs_layer_seq.sv
// Directed testbench for inv_subs_layer_seq: default instance checked every
// cycle against a block-level model, plus SIZE=128/NPC=8 and NPC=16 instances.
module tb_inv_subs_layer_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Default instance: SIZE=64, NPC=4, K=4.
    logic        iv = 1'b0, ordy = 1'b0;
    logic [63:0] id = '0;
    logic        irdy, ov, bsy;
    logic [63:0] od;

    inv_subs_layer_seq #(.SIZE(64), .NPC(4)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(irdy), .in_data(id),
        .out_valid(ov), .out_ready(ordy), .out_data(od), .busy(bsy));

    // Wide instance: SIZE=128, NPC=8, K=4.
    logic         w_iv = 1'b0, w_ordy = 1'b0;
    logic [127:0] w_id = '0;
    logic         w_irdy, w_ov, w_bsy;
    logic [127:0] w_od;

    inv_subs_layer_seq #(.SIZE(128), .NPC(8)) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_iv), .in_ready(w_irdy), .in_data(w_id),
        .out_valid(w_ov), .out_ready(w_ordy), .out_data(w_od), .busy(w_bsy));

    // Single-beat instance: SIZE=64, NPC=16, K=1.
    logic        s_iv = 1'b0, s_ordy = 1'b0;
    logic [63:0] s_id = '0;
    logic        s_irdy, s_ov, s_bsy;
    logic [63:0] s_od;

    inv_subs_layer_seq #(.SIZE(64), .NPC(16)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_irdy), .in_data(s_id),
        .out_valid(s_ov), .out_ready(s_ordy), .out_data(s_od), .busy(s_bsy));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- block-level model of the default instance ----------------
    localparam int MK = 4;
    logic [3:0] inv_tab [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                 4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

    function automatic logic [63:0] inv_sub(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = inv_tab[x[4*i +: 4]];
        return r;
    endfunction

    bit          m_live  = 0;
    bit          m_busy  = 0;
    int          m_left  = 0;
    bit          m_known = 0;
    logic [63:0] m_data  = '0;

    // Model: accepted block finishes MK cycles later, waits for out_ready.
    always @(posedge clk) begin
        if (rst) begin
            m_live = 1; m_busy = 0; m_left = 0; m_known = 1; m_data = '0;
        end else if (!m_busy) begin
            if (iv) begin
                m_busy = 1; m_left = MK; m_known = 0; m_data = inv_sub(id);
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_known = 1;
        end else if (ordy) begin
            m_busy = 0;
        end
    end

    // Compare every cycle away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            check("cyc in_ready", irdy, !m_busy);
            check("cyc out_valid", ov, m_busy && m_left == 0);
            check("cyc busy", bsy, m_busy);
            if (m_known) check("cyc out_data", od, m_data);
        end
    end

    // ---------------- directed sequences ----------------
    task automatic run_block(input logic [63:0] din, input logic [63:0] exp, input string name);
        int n;
        iv = 1'b1; id = din;
        tick();
        iv = 1'b0; id = ~din;        // later in_data changes must not matter
        n = 0;
        while (!ov && n < 20) begin tick(); n++; end
        check({name, " latency"}, n, 4);
        check({name, " data"}, od, exp);
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
        check({name, " in_ready after hs"}, irdy, 1'b1);
        check({name, " out_valid after hs"}, ov, 1'b0);
    endtask

    initial begin
        int n;
        int acc;
        logic [63:0] held;

        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset in_ready", irdy, 1'b1);
        check("reset out_valid", ov, 1'b0);
        check("reset busy", bsy, 1'b0);
        check("reset out_data", od, 64'h0);

        run_block(64'h0123456789ABCDEF, 64'h5EF8C12DB463079A, "basic");
        run_block(64'hCCCCCCCCCCCCCCCC, 64'h0000000000000000, "roundtrip C");
        run_block(64'h5555555555555555, 64'h1111111111111111, "roundtrip 5");

        // Backpressure with in_valid held high throughout.
        iv = 1'b1; id = 64'h0123456789ABCDEF;
        tick();
        id = 64'hDEADBEEFCAFEF00D;
        n = 0;
        while (!ov && n < 20) begin tick(); n++; end
        check("bp latency", n, 4);
        held = od;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp data stable", od, 64'h5EF8C12DB463079A);
            check("bp in_ready low", irdy, 1'b0);
            check("bp out_valid hold", ov, 1'b1);
        end
        check("bp held data", held, 64'h5EF8C12DB463079A);
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
        id = 64'h5555555555555555;
        check("bp hs in_ready", irdy, 1'b1);
        check("bp hs busy", bsy, 1'b0);
        tick();
        check("bp next accepted busy", bsy, 1'b1);
        check("bp next accepted in_ready", irdy, 1'b0);
        iv = 1'b0;
        n = 0;
        while (!ov && n < 20) begin tick(); n++; end
        check("bp next latency", n, 4);
        check("bp next data", od, 64'h1111111111111111);
        ordy = 1'b1; tick(); ordy = 1'b0;

        // Reset mid-RUN, with in_valid asserted alongside rst.
        iv = 1'b1; id = 64'h0123456789ABCDEF;
        tick();
        iv = 1'b0;
        tick();
        rst = 1'b1; iv = 1'b1; id = 64'h1234123412341234;
        tick();
        rst = 1'b0; iv = 1'b0;
        check("midrst out_valid", ov, 1'b0);
        check("midrst out_data", od, 64'h0);
        check("midrst in_ready", irdy, 1'b1);
        check("midrst busy", bsy, 1'b0);
        run_block(64'hFFFFFFFFFFFFFFFF, 64'hAAAAAAAAAAAAAAAA, "after rst");

        // SIZE=128, NPC=8.
        w_iv = 1'b1; w_id = 128'h0123456789ABCDEF_FEDCBA9876543210;
        tick();
        w_iv = 1'b0; w_id = '0;
        check("w128 busy", w_bsy, 1'b1);
        n = 0;
        while (!w_ov && n < 20) begin tick(); n++; end
        check("w128 latency", n, 4);
        check("w128 data", w_od, 128'h5EF8C12DB463079A_A970364BD21C8FE5);
        w_ordy = 1'b1; tick(); w_ordy = 1'b0;
        check("w128 in_ready after hs", w_irdy, 1'b1);

        // SIZE=64, NPC=16: single beat.
        s_iv = 1'b1; s_id = 64'h0123456789ABCDEF;
        tick();
        s_iv = 1'b0;
        n = 0;
        while (!s_ov && n < 20) begin tick(); n++; end
        check("k1 latency", n, 1);
        check("k1 data", s_od, 64'h5EF8C12DB463079A);
        s_ordy = 1'b1; tick();
        check("k1 in_ready after hs", s_irdy, 1'b1);

        // Streaming with out_ready held high: one block every 3 cycles.
        s_iv = 1'b1; s_id = 64'hFFFFFFFFFFFFFFFF;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            if (s_irdy) acc++;
            if (s_ov) check("k1 stream data", s_od, 64'hAAAAAAAAAAAAAAAA);
            if (i == 1) check("k1 stream busy", s_bsy, 1'b1);
            tick();
        end
        check("k1 stream accepts in 12 cycles", acc, 4);
        s_iv = 1'b0; s_ordy = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
